// File: rtl/run_sequencer.sv
// run_sequencer: run controller for the processor core.
// Turns the START/DONE handshake into core sequencing: holds the datapath and
// controlpath in reset, releases them for a run, and gates execution until the
// controlpath reports HALT. It also counts the cycles spent in RUN.
// Optional feature: define RUN_SEQ_WATCHDOG_EN to end a run forcibly after
// WDOG_LIMIT RUN cycles (TIMEOUT flags it). Without the macro, TIMEOUT is 0.
module run_sequencer #(
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             halt_i,
    output logic             core_reset_o,
    output logic             core_en_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FINISH
    } state_e;

    localparam int              RC_W    = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(RST_CYCLES);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

`ifdef RUN_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);
    logic timeout_q, timeout_d;
`endif

    // State register; reset puts the core straight back into IDLE (core reset).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter registers: reset-wait counter, RUN cycle counter, timeout flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
`ifdef RUN_SEQ_WATCHDOG_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
`ifdef RUN_SEQ_WATCHDOG_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    // Next-state and next-counter logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
`ifdef RUN_SEQ_WATCHDOG_EN
        timeout_d     = timeout_q;
`endif
        unique case (state_q)
            S_IDLE, S_FINISH: begin
                // A new run starts from a clean slate: counters cleared on entry
                // to CLEAR. FINISH keeps everything frozen otherwise.
                if (start_i) begin
                    state_d       = S_CLEAR;
                    rst_cnt_d     = '0;
                    cycle_count_d = '0;
`ifdef RUN_SEQ_WATCHDOG_EN
                    timeout_d     = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                if (rst_cnt_q != RC_MAX) begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
                // Core reset must be held long enough and START must be gone,
                // so a long START simply stretches CLEAR.
                if ((rst_cnt_q >= RC_LAST) && !start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The HALT cycle is itself an executed cycle, so it is counted.
                if (cycle_count_q != {CNT_W{1'b1}}) begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
                if (halt_i) begin
                    state_d = S_FINISH;
`ifdef RUN_SEQ_WATCHDOG_EN
                end else if (cycle_count_q == WDOG_LAST) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        core_reset_o = 1'b0;
        core_en_o    = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            S_IDLE, S_CLEAR: core_reset_o = 1'b1;
            S_RUN:           core_en_o    = 1'b1;
            S_FINISH:        done_o       = 1'b1;
            default:         core_reset_o = 1'b1;
        endcase
    end

    assign cycle_count_o = cycle_count_q;

`ifdef RUN_SEQ_WATCHDOG_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer (RST_CYCLES=2, WDOG_LIMIT=16).
// Watchdog-specific expectations apply when RUN_SEQ_WATCHDOG_EN is defined.
module tb_run_sequencer;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             halt;
    logic             core_reset;
    logic             core_en;
    logic             done;
    logic [CNT_W-1:0] cycle_count;
    logic             timeout;

    int checks = 0;
    int errors = 0;
    int en_cycles;
    int clr_cycles;

    run_sequencer #(
        .RST_CYCLES (2),
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .halt_i        (halt),
        .core_reset_o  (core_reset),
        .core_en_o     (core_en),
        .done_o        (done),
        .cycle_count_o (cycle_count),
        .timeout_o     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle START pulse; returns in the first RUN cycle (count 0).
    task automatic begin_run();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        halt  = 1'b0;
        step();
        step();
        check("rst_core_reset", core_reset, 1);
        check("rst_core_en", core_en, 0);
        check("rst_done", done, 0);
        check("rst_count", cycle_count, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;

        // Spurious HALT in IDLE: nothing happens.
        halt = 1'b1;
        step();
        check("idle_halt_core_reset", core_reset, 1);
        check("idle_halt_core_en", core_en, 0);
        check("idle_halt_done", done, 0);

        // Normal run; HALT also high during CLEAR and must be ignored.
        start = 1'b1;
        step();
        check("clear1_core_reset", core_reset, 1);
        start = 1'b0;
        step();
        check("clear2_core_reset", core_reset, 1);
        check("clear2_core_en", core_en, 0);
        halt = 1'b0;
        step();
        check("run_entry_core_reset", core_reset, 0);
        check("run_entry_core_en", core_en, 1);
        check("run_entry_count", cycle_count, 0);
        en_cycles = 1;
        for (int i = 1; i <= 9; i++) begin
            start = (i == 5);
            step();
            if (core_en) en_cycles++;
            if (i == 5) check("run_start_ignored_count", cycle_count, 5);
        end
        start = 1'b0;
        halt  = 1'b1;
        step();
        halt  = 1'b0;
        if (core_en) en_cycles++;
        check("run1_en_cycles", en_cycles, 10);
        check("run1_done", done, 1);
        check("run1_count", cycle_count, 10);
        check("run1_timeout", timeout, 0);
        check("run1_core_reset", core_reset, 0);
        step();
        step();
        check("finish_hold_done", done, 1);
        check("finish_hold_count", cycle_count, 10);

        // Restart from FINISH.
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_done", done, 0);
        check("restart_count", cycle_count, 0);
        check("restart_core_reset", core_reset, 1);
        step();
        step();
        check("run2_core_en", core_en, 1);
        step();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("run2_done", done, 1);
        check("run2_count", cycle_count, 3);

        // Long START: five CLEAR cycles, RUN right after START falls.
        start = 1'b1;
        clr_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (core_reset && !core_en && !done) clr_cycles++;
        end
        check("long_start_clear_cycles", clr_cycles, 5);
        start = 1'b0;
        step();
        check("long_start_run_core_en", core_en, 1);
        check("long_start_run_count", cycle_count, 0);

        // Run without HALT up to the watchdog limit.
        for (int i = 0; i < 15; i++) step();
        check("pre_limit_count", cycle_count, 15);
        check("pre_limit_core_en", core_en, 1);
        step();
        check("limit_count", cycle_count, 16);
`ifdef RUN_SEQ_WATCHDOG_EN
        check("wdog_done", done, 1);
        check("wdog_timeout", timeout, 1);
        check("wdog_core_en", core_en, 0);
`else
        check("nowdog_core_en", core_en, 1);
        check("nowdog_done", done, 0);
        check("nowdog_timeout", timeout, 0);
        for (int i = 0; i < 4; i++) step();
        check("nowdog_count_20", cycle_count, 20);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("nowdog_halt_done", done, 1);
        check("nowdog_halt_count", cycle_count, 21);
`endif

        // HALT coinciding with the limit: HALT wins, no timeout.
        begin_run();
        check("run4_count0", cycle_count, 0);
        for (int i = 0; i < 15; i++) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_at_limit_done", done, 1);
        check("halt_at_limit_count", cycle_count, 16);
        check("halt_at_limit_timeout", timeout, 0);

        // Asynchronous reset mid-RUN: takes effect before the next edge.
        begin_run();
        step();
        step();
        step();
        check("pre_rst_count", cycle_count, 3);
        rst = 1'b1;
        #1;
        check("async_rst_core_reset", core_reset, 1);
        check("async_rst_core_en", core_en, 0);
        check("async_rst_count", cycle_count, 0);
        check("async_rst_done", done, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle_core_reset", core_reset, 1);
        check("post_rst_timeout", timeout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
